// File: rtl/nco_sweep_controller_pkg.sv
// Shared definitions for the NCO sweep controller: FSM state encoding and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nco_sweep_controller_pkg;

    localparam int PHASE_W_DEF = 32;  // 2^PHASE_W = one full rotation
    localparam int COUNT_W_DEF = 16;  // sweep step count width
    localparam int DWELL_W_DEF = 16;  // dwell length width, in i_adcClock cycles

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } state_t;

endpackage

// File: rtl/nco_sweep_controller_dwell_timer.sv
// Loadable down-counter with a terminal-count flag; measures how long each sweep frequency is held.
// Latency: tc is high during the cycle the count register holds 1 (registered, no comb path from load).
// Backpressure: none; a load always wins over the decrement. The count stops at 0.
// Ports: i_adcClock/i_resetn clock and async active-low reset; i_load/i_value reload request and
//        value; o_tc terminal count (counter == 1).
module nco_dwell_timer
    import nco_sweep_controller_pkg::*;
#(
    parameter int W = DWELL_W_DEF
) (
    input  logic         i_adcClock,
    input  logic         i_resetn,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge i_adcClock or negedge i_resetn) begin
        if (!i_resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal count on 1 rather than 0: the value loaded equals the number of cycles held.
    assign o_tc = (cnt_q == W'(1));

endmodule

// File: rtl/nco_sweep_controller.sv
// Sequences the NCO phase increment: fixed retunes or linear sweeps with per-step dwell and abort.
// Latency: a command is applied on its acceptance edge; each sweep frequency is held exactly dwell cycles.
// Backpressure: o_cmdReady is low only while a sweep is dwelling; in IDLE commands go back-to-back.
// Ports: i_adcClock/i_resetn clock and async active-low reset; i_cmdValid/o_cmdReady command handshake;
//        i_cmdSweep/Start/Step/Count/Dwell/PhaseClear command fields; i_abort stops a running sweep;
//        o_phaseDelta accumulator increment; o_phaseClear/o_stepStrobe/o_sweepDone 1-cycle pulses;
//        o_sweepActive high while dwelling.
module nco_sweep_controller
    import nco_sweep_controller_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int COUNT_W = COUNT_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               i_adcClock,
    input  logic               i_resetn,
    input  logic               i_cmdValid,
    output logic               o_cmdReady,
    input  logic               i_cmdSweep,
    input  logic [PHASE_W-1:0] i_cmdStart,
    input  logic [PHASE_W-1:0] i_cmdStep,
    input  logic [COUNT_W-1:0] i_cmdCount,
    input  logic [DWELL_W-1:0] i_cmdDwell,
    input  logic               i_cmdPhaseClear,
    input  logic               i_abort,
    output logic [PHASE_W-1:0] o_phaseDelta,
    output logic               o_phaseClear,
    output logic               o_stepStrobe,
    output logic               o_sweepActive,
    output logic               o_sweepDone
);

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_delta_q, phase_delta_d;
    logic [PHASE_W-1:0] step_q, step_d;
    logic [COUNT_W-1:0] steps_left_q, steps_left_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               phase_clear_q, phase_clear_d;
    logic               step_strobe_q, step_strobe_d;
    logic               sweep_done_q, sweep_done_d;

    logic               cmd_accept;
    logic [DWELL_W-1:0] cmd_dwell_eff;
    logic               timer_load;
    logic [DWELL_W-1:0] timer_value;
    logic               timer_tc;

    assign o_cmdReady    = (state_q == ST_IDLE);
    assign cmd_accept    = i_cmdValid & o_cmdReady;
    // A zero dwell would never reach terminal count; hold such frequencies for one cycle instead.
    assign cmd_dwell_eff = (i_cmdDwell == '0) ? DWELL_W'(1) : i_cmdDwell;

    always_comb begin
        state_d       = state_q;
        phase_delta_d = phase_delta_q;
        step_d        = step_q;
        steps_left_d  = steps_left_q;
        dwell_d       = dwell_q;
        phase_clear_d = 1'b0;
        step_strobe_d = 1'b0;
        sweep_done_d  = 1'b0;
        timer_load    = 1'b0;
        timer_value   = dwell_q;

        case (state_q)
            ST_IDLE: begin
                // i_abort is meaningless here; a command in the same cycle is taken normally.
                if (cmd_accept) begin
                    phase_delta_d = i_cmdStart;
                    phase_clear_d = i_cmdPhaseClear;
                    // A zero-count sweep is just a retune and never leaves IDLE.
                    if (i_cmdSweep && (i_cmdCount != '0)) begin
                        state_d      = ST_DWELL;
                        step_d       = i_cmdStep;
                        steps_left_d = i_cmdCount;
                        dwell_d      = cmd_dwell_eff;
                        timer_load   = 1'b1;
                        timer_value  = cmd_dwell_eff;
                    end
                end
            end
            ST_DWELL: begin
                // Abort has priority over a step or completion falling due on the same edge.
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (timer_tc) begin
                    if (steps_left_q != '0) begin
                        // Modular add: the signed step wraps around the full rotation.
                        phase_delta_d = phase_delta_q + step_q;
                        steps_left_d  = steps_left_q - COUNT_W'(1);
                        step_strobe_d = 1'b1;
                        timer_load    = 1'b1;
                    end else begin
                        state_d      = ST_IDLE;
                        sweep_done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_adcClock or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q       <= ST_IDLE;
            phase_delta_q <= '0;
            step_q        <= '0;
            steps_left_q  <= '0;
            dwell_q       <= '0;
            phase_clear_q <= 1'b0;
            step_strobe_q <= 1'b0;
            sweep_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_delta_q <= phase_delta_d;
            step_q        <= step_d;
            steps_left_q  <= steps_left_d;
            dwell_q       <= dwell_d;
            phase_clear_q <= phase_clear_d;
            step_strobe_q <= step_strobe_d;
            sweep_done_q  <= sweep_done_d;
        end
    end

    nco_dwell_timer #(
        .W (DWELL_W)
    ) u_dwell_timer (
        .i_adcClock (i_adcClock),
        .i_resetn   (i_resetn),
        .i_load     (timer_load),
        .i_value    (timer_value),
        .o_tc       (timer_tc)
    );

    assign o_phaseDelta  = phase_delta_q;
    assign o_phaseClear  = phase_clear_q;
    assign o_stepStrobe  = step_strobe_q;
    assign o_sweepActive = (state_q == ST_DWELL);
    assign o_sweepDone   = sweep_done_q;

endmodule

// File: tb/tb_nco_sweep_controller.sv
// Randomized and directed bench for nco_sweep_controller with an event scoreboard.
// Latency: n/a.
// Backpressure: the command driver holds i_cmdValid until the controller accepts it.
module tb_nco_sweep_controller;

    logic        i_adcClock;
    logic        i_resetn;
    logic        i_cmdValid;
    logic        o_cmdReady;
    logic        i_cmdSweep;
    logic [31:0] i_cmdStart;
    logic [31:0] i_cmdStep;
    logic [15:0] i_cmdCount;
    logic [15:0] i_cmdDwell;
    logic        i_cmdPhaseClear;
    logic        i_abort;
    logic [31:0] o_phaseDelta;
    logic        o_phaseClear;
    logic        o_stepStrobe;
    logic        o_sweepActive;
    logic        o_sweepDone;

    nco_sweep_controller dut (
        .i_adcClock      (i_adcClock),
        .i_resetn        (i_resetn),
        .i_cmdValid      (i_cmdValid),
        .o_cmdReady      (o_cmdReady),
        .i_cmdSweep      (i_cmdSweep),
        .i_cmdStart      (i_cmdStart),
        .i_cmdStep       (i_cmdStep),
        .i_cmdCount      (i_cmdCount),
        .i_cmdDwell      (i_cmdDwell),
        .i_cmdPhaseClear (i_cmdPhaseClear),
        .i_abort         (i_abort),
        .o_phaseDelta    (o_phaseDelta),
        .o_phaseClear    (o_phaseClear),
        .o_stepStrobe    (o_stepStrobe),
        .o_sweepActive   (o_sweepActive),
        .o_sweepDone     (o_sweepDone)
    );

    // Expected output event: any cycle with a pulse or a change of o_phaseDelta.
    typedef struct {
        int          cyc;
        logic [31:0] phase;
        logic        clr;
        logic        stb;
        logic        done;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;
    int  cyc    = 0;

    // Reference model: the most recent applied command as a closed-form schedule.
    int          m_a     = 0;   // acceptance edge
    int          m_stop  = 1;   // first edge at which the controller is back in IDLE
    int          m_n     = 0;   // steps after start
    int          m_d     = 1;   // effective dwell
    bit          m_sweep = 0;   // command entered DWELL
    logic [31:0] m_start = '0;
    logic [31:0] m_step  = '0;

    initial i_adcClock = 1'b0;
    always #5 i_adcClock = ~i_adcClock;
    always @(posedge i_adcClock) cyc = cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Phase the model predicts for the state after edge c.
    function automatic logic [31:0] phase_at(input int c);
        int cc;
        int k;
        cc = (c < m_stop - 1) ? c : m_stop - 1;
        if (cc < m_a) cc = m_a;
        k = (cc - m_a) / m_d;
        if (k > m_n) k = m_n;
        return m_start + 32'(k) * m_step;
    endfunction

    task automatic model_abort(input int t);
        if (m_sweep && (m_a < t) && (t <= m_stop)) begin
            m_stop = t;
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].cyc >= t) exp_q.delete(i);
            end
        end
    endtask

    // Called just after a posedge. Holds valid until accepted, then records the expected schedule.
    task automatic send_cmd(input bit sw, input logic [31:0] st, input logic [31:0] stp,
                            input int cnt, input int dw, input bit clr, input bit ab);
        int          p;
        int          a_exp;
        int          d;
        int          nn;
        bit          rdy;
        bit          ok;
        logic [31:0] old;
        p = cyc;
        if (ab) model_abort(p + 1);
        a_exp = ((m_sweep && (m_stop > p)) ? m_stop : p) + 1;
        i_cmdValid      = 1'b1;
        i_cmdSweep      = sw;
        i_cmdStart      = st;
        i_cmdStep       = stp;
        i_cmdCount      = 16'(cnt);
        i_cmdDwell      = 16'(dw);
        i_cmdPhaseClear = clr;
        i_abort         = ab;
        ok = 1'b0;
        for (int n = 0; n < 1000 && !ok; n++) begin
            rdy = o_cmdReady;
            @(posedge i_adcClock);
            #1;
            i_abort = 1'b0;
            ok = rdy;
        end
        i_cmdValid      = 1'b0;
        i_cmdSweep      = 1'($urandom);
        i_cmdStart      = $urandom;
        i_cmdStep       = $urandom;
        i_cmdCount      = 16'($urandom);
        i_cmdDwell      = 16'($urandom);
        i_cmdPhaseClear = 1'($urandom);
        chk("accept_cycle", 32'(cyc), 32'(a_exp));

        old = phase_at(a_exp - 1);
        d   = (dw == 0) ? 1 : dw;
        nn  = sw ? cnt : 0;
        m_a     = a_exp;
        m_start = st;
        m_step  = stp;
        m_n     = nn;
        m_d     = d;
        m_sweep = (nn != 0);
        m_stop  = m_sweep ? a_exp + (nn + 1) * d : a_exp + 1;
        if ((st != old) || clr) exp_q.push_back('{a_exp, st, clr, 1'b0, 1'b0});
        for (int k = 1; k <= nn; k++) begin
            exp_q.push_back('{a_exp + k * d, st + 32'(k) * stp, 1'b0, 1'b1, 1'b0});
        end
        if (nn != 0) exp_q.push_back('{m_stop, st + 32'(nn) * stp, 1'b0, 1'b0, 1'b1});
    endtask

    // Assert i_abort so that it is sampled on edge t.
    task automatic abort_at(input int t);
        while (cyc < t - 1) begin
            @(posedge i_adcClock);
            #1;
        end
        model_abort(t);
        i_abort = 1'b1;
        @(posedge i_adcClock);
        #1;
        i_abort = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge i_adcClock);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_phaseDelta"}, o_phaseDelta, 32'h0);
        chk({tag, "_cmdReady"}, 32'(o_cmdReady), 32'h1);
        chk({tag, "_phaseClear"}, 32'(o_phaseClear), 32'h0);
        chk({tag, "_stepStrobe"}, 32'(o_stepStrobe), 32'h0);
        chk({tag, "_sweepActive"}, 32'(o_sweepActive), 32'h0);
        chk({tag, "_sweepDone"}, 32'(o_sweepDone), 32'h0);
    endtask

    // Mid-run reset: asserted between edges, outputs must reset without waiting for a clock.
    task automatic mid_reset();
        @(posedge i_adcClock);
        #2;
        i_resetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        m_a = 0; m_stop = 1; m_n = 0; m_d = 1; m_sweep = 0; m_start = '0; m_step = '0;
        repeat (2) @(posedge i_adcClock);
        #1;
        i_resetn = 1'b1;
    endtask

    // Monitor: per-cycle status checks, and scoreboard pops whenever the DUT shows an event.
    initial begin : monitor
        logic [31:0] prev_phase;
        bit          exp_act;
        bit          ev;
        ev_t         e;
        int          c;
        prev_phase = '0;
        forever begin
            @(negedge i_adcClock);
            if (!i_resetn) begin
                prev_phase = '0;
                continue;
            end
            c = cyc;
            exp_act = m_sweep && (c >= m_a) && (c < m_stop);
            chk("sweepActive", 32'(o_sweepActive), 32'(exp_act));
            chk("cmdReady", 32'(o_cmdReady), 32'(!exp_act));
            while ((exp_q.size() > 0) && (exp_q[0].cyc < c)) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_fail++;
                $display("FAIL missed_event: nothing seen, expected cycle %0d phase 0x%08h clr %0b stb %0b done %0b",
                         e.cyc, e.phase, e.clr, e.stb, e.done);
            end
            ev = (o_phaseDelta != prev_phase) || o_phaseClear || o_stepStrobe || o_sweepDone;
            if (ev) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: cycle %0d phase 0x%08h clr %0b stb %0b done %0b, expected none",
                             c, o_phaseDelta, o_phaseClear, o_stepStrobe, o_sweepDone);
                end else begin
                    e = exp_q.pop_front();
                    if ((e.cyc != c) || (e.phase !== o_phaseDelta) || (e.clr !== o_phaseClear) ||
                        (e.stb !== o_stepStrobe) || (e.done !== o_sweepDone)) begin
                        n_fail++;
                        $display("FAIL event: got cycle %0d phase 0x%08h clr %0b stb %0b done %0b, expected cycle %0d phase 0x%08h clr %0b stb %0b done %0b",
                                 c, o_phaseDelta, o_phaseClear, o_stepStrobe, o_sweepDone,
                                 e.cyc, e.phase, e.clr, e.stb, e.done);
                    end
                end
            end
            prev_phase = o_phaseDelta;
        end
    end

    initial begin : stimulus
        int t;
        i_resetn        = 1'b0;
        i_cmdValid      = 1'b0;
        i_cmdSweep      = 1'b0;
        i_cmdStart      = '0;
        i_cmdStep       = '0;
        i_cmdCount      = '0;
        i_cmdDwell      = '0;
        i_cmdPhaseClear = 1'b0;
        i_abort         = 1'b0;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge i_adcClock);
        #1;
        i_resetn = 1'b1;
        idle_cycles(2);

        // Fixed retune with phase clear, then a back-to-back retune.
        send_cmd(1'b0, 32'h0100_0000, 32'h0, 0, 0, 1'b1, 1'b0);
        send_cmd(1'b0, 32'h0200_0000, 32'h0, 0, 0, 1'b0, 1'b0);
        idle_cycles(2);
        // Basic sweep: 100/110/120/130, 4 cycles each.
        send_cmd(1'b1, 32'd100, 32'd10, 3, 4, 1'b0, 1'b0);
        idle_cycles(20);
        // Wrap through zero, then a negative step.
        send_cmd(1'b1, 32'hFFFF_FFF0, 32'h20, 1, 2, 1'b0, 1'b0);
        idle_cycles(6);
        send_cmd(1'b1, 32'd5, 32'hFFFF_FFFD, 2, 3, 1'b1, 1'b0);
        idle_cycles(12);
        // Abort on the edge where the first step is due.
        send_cmd(1'b1, 32'd1000, 32'd7, 5, 3, 1'b0, 1'b0);
        abort_at(m_a + 3);
        idle_cycles(3);
        // Dwell 0 behaves as dwell 1.
        send_cmd(1'b1, 32'h1234_0000, 32'h10, 2, 0, 1'b0, 1'b0);
        idle_cycles(5);
        // Valid held through a sweep: taken the cycle after done.
        send_cmd(1'b1, 32'd50, 32'd1, 2, 3, 1'b0, 1'b0);
        send_cmd(1'b0, 32'hABCD_0000, 32'h0, 0, 0, 1'b1, 1'b0);
        // Abort in IDLE with a same-cycle command: ignored, command applied.
        send_cmd(1'b1, 32'h0000_0777, 32'h3, 2, 2, 1'b0, 1'b1);
        idle_cycles(8);
        // Zero-count sweep behaves as a retune.
        send_cmd(1'b1, 32'h0000_4444, 32'h1, 0, 5, 1'b0, 1'b0);
        idle_cycles(2);
        // Reset in the middle of a sweep.
        send_cmd(1'b1, 32'h0F00_0000, 32'h100, 4, 5, 1'b0, 1'b0);
        idle_cycles(7);
        mid_reset();
        idle_cycles(3);

        // Randomized commands, gaps, held valids and aborts.
        for (int i = 0; i < 40; i++) begin
            idle_cycles($urandom_range(0, 3));
            send_cmd(1'($urandom), $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 4),
                     1'($urandom), ($urandom_range(0, 7) == 0));
            if (m_sweep && ($urandom_range(0, 2) == 0)) begin
                t = m_a + $urandom_range(1, m_stop - m_a);
                abort_at(t);
            end
        end

        for (int n = 0; n < 1000 && cyc < m_stop + 3; n++) idle_cycles(1);
        idle_cycles(2);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
